// File: rtl/pipelined_alu_pkg.sv
// Shared definitions for the pipelined ALU: opcode encoding and status flags.
package pipelined_alu_pkg;

  // Opcodes; the original four keep their codes, the rest fill in around them.
  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_XOR  = 4'b0011,
    OP_SLL  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_SUB  = 4'b0110,
    OP_SLT  = 4'b0111,
    OP_SRA  = 4'b1000,
    OP_SLTU = 4'b1001,
    OP_NOR  = 4'b1100
  } alu_op_e;

  // Status flags produced alongside every result.
  typedef struct packed {
    logic zero;
    logic neg;
    logic carry;
    logic ovf;
    logic illegal;
  } alu_flags_t;

endpackage

// File: rtl/pipelined_alu_core.sv
// Combinational ALU evaluation: result and flags for one op.
// Ports: a_i/b_i operands, op_i opcode, result_o result, flags_o status flags.
module pipelined_alu_core
  import pipelined_alu_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [3:0]   op_i,
  output logic [W-1:0] result_o,
  output alu_flags_t   flags_o
);

  localparam int unsigned SH_W = $clog2(W);

  logic [SH_W-1:0] shamt;
  logic [W:0]      sum;
  logic [W:0]      diff;

  assign shamt = b_i[SH_W-1:0];
  assign sum   = {1'b0, a_i} + {1'b0, b_i};
  assign diff  = {1'b0, a_i} - {1'b0, b_i};

  // Op select; zero/neg are derived from the final result for every op.
  always_comb begin
    result_o = '0;
    flags_o  = '0;
    case (alu_op_e'(op_i))
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      OP_NOR:  result_o = ~(a_i | b_i);
      OP_ADD: begin
        result_o      = sum[W-1:0];
        flags_o.carry = sum[W];
        flags_o.ovf   = (a_i[W-1] == b_i[W-1]) && (sum[W-1] != a_i[W-1]);
      end
      OP_SUB: begin
        result_o      = diff[W-1:0];
        flags_o.carry = ~diff[W];  // no borrow: a >= b unsigned
        flags_o.ovf   = (a_i[W-1] != b_i[W-1]) && (diff[W-1] != a_i[W-1]);
      end
      OP_SLL:  result_o = a_i << shamt;
      OP_SRL:  result_o = a_i >> shamt;
      OP_SRA:  result_o = $unsigned($signed(a_i) >>> shamt);
      OP_SLT:  result_o = {{(W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      OP_SLTU: result_o = {{(W-1){1'b0}}, (a_i < b_i)};
      default: flags_o.illegal = 1'b1;
    endcase
    flags_o.zero = (result_o == '0);
    flags_o.neg  = result_o[W-1];
  end

endmodule

// File: rtl/pipelined_alu.sv
// Pipelined ALU with valid/ready on both sides. Ops are evaluated on accept,
// then ride STAGES registers with bubble collapsing; the tail drives out_*.
// Ports: in_valid/in_ready/in_a/in_b/in_op/in_tag upstream handshake and op;
// out_valid/out_ready/out_result/out_zero/out_neg/out_carry/out_ovf/
// out_illegal/out_tag downstream handshake, result, flags and tag.
module pipelined_alu
  import pipelined_alu_pkg::*;
#(
  parameter int unsigned W      = 32,
  parameter int unsigned STAGES = 2,
  parameter int unsigned TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [3:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_result,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  typedef struct packed {
    logic [W-1:0]     result;
    alu_flags_t       flags;
    logic [TAG_W-1:0] tag;
  } stage_t;

  logic [W-1:0]      core_result;
  alu_flags_t        core_flags;
  stage_t            in_stage;
  stage_t            data_q [STAGES];
  stage_t            data_d [STAGES];
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;
  logic [STAGES-1:0] ld;
  stage_t            out_stage;

  pipelined_alu_core #(.W(W)) u_core (
    .a_i      (in_a),
    .b_i      (in_b),
    .op_i     (in_op),
    .result_o (core_result),
    .flags_o  (core_flags)
  );

  assign in_stage = {core_result, core_flags, in_tag};

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    stage_t src;
    logic   src_v;

    // A stage may load if it or any stage behind it towards the tail has a
    // hole, or the tail is draining this cycle.
    assign ld[g] = out_ready | ~(&valid_q[STAGES-1:g]);

    if (g == 0) begin : g_head
      assign src   = in_stage;
      assign src_v = in_valid;
    end else begin : g_body
      assign src   = data_q[g-1];
      assign src_v = valid_q[g-1];
    end

    assign valid_d[g] = ld[g] ? src_v : valid_q[g];
    assign data_d[g]  = (ld[g] && src_v) ? src : data_q[g];

    // Stage register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q[g] <= 1'b0;
        data_q[g]  <= '0;
      end else begin
        valid_q[g] <= valid_d[g];
        data_q[g]  <= data_d[g];
      end
    end
  end

  assign in_ready = ld[0];

  // Tail outputs read zero whenever no result is being offered.
  assign out_valid   = valid_q[STAGES-1];
  assign out_stage   = valid_q[STAGES-1] ? data_q[STAGES-1] : '0;
  assign out_result  = out_stage.result;
  assign out_zero    = out_stage.flags.zero;
  assign out_neg     = out_stage.flags.neg;
  assign out_carry   = out_stage.flags.carry;
  assign out_ovf     = out_stage.flags.ovf;
  assign out_illegal = out_stage.flags.illegal;
  assign out_tag     = out_stage.tag;

endmodule

// File: tb/tb_pipelined_alu.sv
// Directed bench for pipelined_alu (W=32, STAGES=2, TAG_W=5).
module tb_pipelined_alu;
  import pipelined_alu_pkg::*;

  localparam int unsigned W      = 32;
  localparam int unsigned STAGES = 2;
  localparam int unsigned TAG_W  = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     in_a = '0;
  logic [W-1:0]     in_b = '0;
  logic [3:0]       in_op = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [W-1:0]     out_result;
  logic             out_zero, out_neg, out_carry, out_ovf, out_illegal;
  logic [TAG_W-1:0] out_tag;
  logic [4:0]       fl;

  int tests = 0;
  int fails = 0;

  pipelined_alu #(.W(W), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_neg(out_neg),
    .out_carry(out_carry), .out_ovf(out_ovf), .out_illegal(out_illegal),
    .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  // {zero, neg, carry, ovf, illegal}
  assign fl = {out_zero, out_neg, out_carry, out_ovf, out_illegal};

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", name, got, exp);
    end
  endtask

  // Single op through an idle pipeline with out_ready high; called at posedge+1.
  task automatic run_one(input string name, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [TAG_W-1:0] tag,
                         input logic [W-1:0] exp_res, input logic [4:0] exp_fl);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    #1;
    check({name, ".in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({name, ".lat1"}, 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check({name, ".valid"}, 64'(out_valid), 64'd1);
    check({name, ".result"}, 64'(out_result), 64'(exp_res));
    check({name, ".flags"}, 64'(fl), 64'(exp_fl));
    check({name, ".tag"}, 64'(out_tag), 64'(tag));
    @(posedge clk); #1;
    check({name, ".drain"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  sent, rcv;
    bit  prev_stall, saw_full, hs_in, hs_out;
    logic [W-1:0]     prev_res;
    logic [TAG_W-1:0] prev_tag;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.out_result", 64'(out_result), 64'd0);
    rst_n = 1'b1;
    #1;
    check("rst.in_ready", 64'(in_ready), 64'd1);
    check("rst.flags", 64'(fl), 64'd0);
    check("rst.tag", 64'(out_tag), 64'd0);
    @(posedge clk); #1;

    // Directed single ops: result, {zero,neg,carry,ovf,illegal}
    run_one("add_ovf",  OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 5'd1,  32'h8000_0000, 5'b01010);
    run_one("add_cry",  OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 5'd2,  32'h0000_0000, 5'b10100);
    run_one("sub_eq",   OP_SUB,  32'd5,         32'd5,         5'd3,  32'h0000_0000, 5'b10100);
    run_one("sub_lt",   OP_SUB,  32'd3,         32'd5,         5'd4,  32'hFFFF_FFFE, 5'b01000);
    run_one("slt",      OP_SLT,  32'hFFFF_FFFF, 32'd1,         5'd5,  32'h0000_0001, 5'b00000);
    run_one("sltu",     OP_SLTU, 32'hFFFF_FFFF, 32'd1,         5'd6,  32'h0000_0000, 5'b10000);
    run_one("sra",      OP_SRA,  32'h8000_0000, 32'h0000_0024, 5'd7,  32'hF800_0000, 5'b01000);
    run_one("srl",      OP_SRL,  32'h8000_0000, 32'h0000_0024, 5'd8,  32'h0800_0000, 5'b00000);
    run_one("sra_pos",  OP_SRA,  32'h4000_0000, 32'h0000_0021, 5'd9,  32'h2000_0000, 5'b00000);
    run_one("sll",      OP_SLL,  32'h0000_0001, 32'd31,        5'd10, 32'h8000_0000, 5'b01000);
    run_one("and",      OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd11, 32'hF000_F000, 5'b01000);
    run_one("or",       OP_OR,   32'h0000_0001, 32'h0000_0002, 5'd12, 32'h0000_0003, 5'b00000);
    run_one("xor",      OP_XOR,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13, 32'h0000_0000, 5'b10000);
    run_one("nor",      OP_NOR,  32'h0000_0000, 32'h0000_0000, 5'd14, 32'hFFFF_FFFF, 5'b01000);
    run_one("ill_f",    4'b1111, 32'h1234_5678, 32'h8765_4321, 5'd15, 32'h0000_0000, 5'b10001);
    run_one("ill_a",    4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd16, 32'h0000_0000, 5'b10001);

    // Stream 10 ADDs (a=i, b=100) with out_ready pattern 1,0,0 repeating
    sent = 0; rcv = 0; prev_stall = 1'b0; saw_full = 1'b0;
    prev_res = '0; prev_tag = '0;
    for (int cyc = 0; cyc < 200 && rcv < 10; cyc++) begin
      out_ready = (cyc % 3 == 0);
      in_valid  = (sent < 10);
      in_op     = OP_ADD;
      in_a      = W'(sent);
      in_b      = 32'd100;
      in_tag    = TAG_W'(sent);
      #1;
      check("stream.in_ready", 64'(in_ready), 64'(!((sent - rcv) == 2 && !out_ready)));
      if (!in_ready) saw_full = 1'b1;
      if (prev_stall) begin
        check("stream.hold_valid", 64'(out_valid), 64'd1);
        check("stream.hold_result", 64'(out_result), 64'(prev_res));
        check("stream.hold_tag", 64'(out_tag), 64'(prev_tag));
      end
      if (out_valid) begin
        check("stream.tag", 64'(out_tag), 64'(rcv));
        check("stream.result", 64'(out_result), 64'(100 + rcv));
      end
      hs_in      = in_valid && in_ready;
      hs_out     = out_valid && out_ready;
      prev_stall = out_valid && !out_ready;
      prev_res   = out_result;
      prev_tag   = out_tag;
      @(posedge clk); #1;
      if (hs_in)  sent++;
      if (hs_out) rcv++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream.count", 64'(rcv), 64'd10);
    check("stream.saw_full", 64'(saw_full), 64'd1);
    @(posedge clk); #1;
    check("stream.empty", 64'(out_valid), 64'd0);

    // Reset with two ops in flight
    in_valid = 1'b1; in_op = OP_ADD; in_a = 32'd1; in_b = 32'd1; in_tag = 5'd21;
    @(posedge clk); #1;
    in_a = 32'd2; in_tag = 5'd22;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("rst2.pre_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst2.async_valid", 64'(out_valid), 64'd0);
    check("rst2.async_result", 64'(out_result), 64'd0);
    check("rst2.async_tag", 64'(out_tag), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    check("rst2.in_ready", 64'(in_ready), 64'd1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("rst2.no_stale", 64'(out_valid), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
